// File: rtl/sync_fifo_param.sv
// Parametrised single-clock FIFO with occupancy count, almost-full/almost-empty
// thresholds, sticky overflow/underflow flags and a build-time choice between
// registered-read and first-word-fall-through output.
module sync_fifo_param #(
  parameter int unsigned DATA_W   = 32,
  parameter int unsigned ADDR_W   = 4,
  parameter int unsigned AF_LEVEL = 12,
  parameter int unsigned AE_LEVEL = 2,
  parameter int unsigned FWFT     = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              w_en,
  input  logic [DATA_W-1:0] data_in,
  input  logic              r_en,
  input  logic              clr_err,
  output logic [DATA_W-1:0] data_out,
  output logic              data_valid,
  output logic              full,
  output logic              empty,
  output logic              almost_full,
  output logic              almost_empty,
  output logic [ADDR_W:0]   count,
  output logic              overflow,
  output logic              underflow
);

  localparam int unsigned     DEPTH   = 1 << ADDR_W;
  localparam logic [ADDR_W:0] AfLevel = (ADDR_W + 1)'(AF_LEVEL);
  localparam logic [ADDR_W:0] AeLevel = (ADDR_W + 1)'(AE_LEVEL);
  localparam logic [ADDR_W:0] PtrOne  = (ADDR_W + 1)'(1);

  logic [DATA_W-1:0] mem [DEPTH];

  // Pointers carry one extra wrap bit above the index bits.
  logic [ADDR_W:0]   w_ptr_q, w_ptr_d;
  logic [ADDR_W:0]   r_ptr_q, r_ptr_d;
  logic [ADDR_W:0]   count_q, count_d;
  logic              overflow_q, overflow_d;
  logic              underflow_q, underflow_d;
  logic [ADDR_W-1:0] w_idx, r_idx;
  logic              wr_ok, rd_ok;

  assign w_idx = w_ptr_q[ADDR_W-1:0];
  assign r_idx = r_ptr_q[ADDR_W-1:0];

  // Flags come only from registered state, so w_en/r_en never reach them.
  assign full  = (w_ptr_q[ADDR_W] != r_ptr_q[ADDR_W]) && (w_idx == r_idx);
  assign empty = (w_ptr_q == r_ptr_q);

  assign almost_full  = (count_q >= AfLevel);
  assign almost_empty = (count_q <= AeLevel);
  assign count        = count_q;
  assign overflow     = overflow_q;
  assign underflow    = underflow_q;

  // Acceptance is judged against the pre-edge full/empty flags.
  assign wr_ok = w_en && !full;
  assign rd_ok = r_en && !empty;

  // Next-state for pointers, occupancy and sticky error flags.
  always_comb begin
    w_ptr_d     = w_ptr_q;
    r_ptr_d     = r_ptr_q;
    count_d     = count_q;
    overflow_d  = overflow_q;
    underflow_d = underflow_q;

    if (wr_ok) w_ptr_d = w_ptr_q + PtrOne;
    if (rd_ok) r_ptr_d = r_ptr_q + PtrOne;

    unique case ({wr_ok, rd_ok})
      2'b10:   count_d = count_q + PtrOne;
      2'b01:   count_d = count_q - PtrOne;
      default: count_d = count_q;
    endcase

    // Clear first so a coincident set wins.
    if (clr_err) begin
      overflow_d  = 1'b0;
      underflow_d = 1'b0;
    end
    if (w_en && full)  overflow_d  = 1'b1;
    if (r_en && empty) underflow_d = 1'b1;
  end

  // Control state registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      w_ptr_q     <= '0;
      r_ptr_q     <= '0;
      count_q     <= '0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      w_ptr_q     <= w_ptr_d;
      r_ptr_q     <= r_ptr_d;
      count_q     <= count_d;
      overflow_q  <= overflow_d;
      underflow_q <= underflow_d;
    end
  end

  // Storage array; not reset, and a write coinciding with reset is dropped.
  always_ff @(posedge clk) begin
    if (!rst && wr_ok) begin
      mem[w_idx] <= data_in;
    end
  end

  if (FWFT == 0) begin : g_reg_read
    logic [DATA_W-1:0] rdata_q;
    logic              rvalid_q;

    // Registered read: data lands one cycle after an accepted r_en.
    always_ff @(posedge clk) begin
      if (rst) begin
        rdata_q  <= '0;
        rvalid_q <= 1'b0;
      end else begin
        rvalid_q <= rd_ok;
        if (rd_ok) rdata_q <= mem[r_idx];
      end
    end

    assign data_out   = rdata_q;
    assign data_valid = rvalid_q;
  end else begin : g_fwft_read
    // Head word is always presented; meaningless while empty.
    assign data_out   = mem[r_idx];
    assign data_valid = !empty;
  end

endmodule
